// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment reader.
// Holds the active-low segment encodings (bit6..bit0 = g..a) for digits 0-9,
// the blank pattern, and the digit code loaded for a blanked position.
package seven_seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0     = 7'b1000000;
    localparam seg_t SEG_1     = 7'b1111001;
    localparam seg_t SEG_2     = 7'b0100100;
    localparam seg_t SEG_3     = 7'b0110000;
    localparam seg_t SEG_4     = 7'b0011001;
    localparam seg_t SEG_5     = 7'b0010010;
    localparam seg_t SEG_6     = 7'b0000010;
    localparam seg_t SEG_7     = 7'b1111000;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0010000;
    localparam seg_t SEG_BLANK = 7'b1111111;

    localparam logic [3:0] DIGIT_BLANK = 4'hF;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational decoder from an active-low segment pattern to a digit.
// Ports:
//   seg      - segment pattern (g..a, active low)
//   value    - decoded digit 0-9, DIGIT_BLANK for blank or unknown patterns
//   is_blank - pattern is all segments off
//   is_err   - pattern is neither a digit nor blank
module seg_pattern_decode
    import seven_seg_pkg::*;
(
    input  seg_t       seg,
    output logic [3:0] value,
    output logic       is_blank,
    output logic       is_err
);

    always_comb begin
        value    = DIGIT_BLANK;
        is_blank = 1'b0;
        is_err   = 1'b0;
        case (seg)
            SEG_0:     value = 4'd0;
            SEG_1:     value = 4'd1;
            SEG_2:     value = 4'd2;
            SEG_3:     value = 4'd3;
            SEG_4:     value = 4'd4;
            SEG_5:     value = 4'd5;
            SEG_6:     value = 4'd6;
            SEG_7:     value = 4'd7;
            SEG_8:     value = 4'd8;
            SEG_9:     value = 4'd9;
            SEG_BLANK: is_blank = 1'b1;
            default:   is_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/seven_segment_reader.sv
// Reads back a multiplexed seven-segment display from its segment and
// digit-enable lines. Inputs are synchronized, each {an,seg} sample must dwell
// for STABLE_CYCLES identical samples before it is accepted once, and the
// accepted pattern is decoded into the addressed position.
// Ports:
//   clk, reset   - clock, asynchronous active-high reset
//   seg_in       - active-low segments g..a
//   an_in        - active-low digit enables, one low at a time when valid
//   digits       - 4 bits per position, position i at [4i+3:4i]
//   digit_valid  - position holds a decoded 0-9
//   frame_done   - pulse once every position has been accepted
//   pattern_err  - pulse on acceptance of an undecodable pattern
//   err_count    - saturating error counter (only with SEG_READER_ERR_CNT_EN)
// Build option: define SEG_READER_ERR_CNT_EN to add err_count.
module seven_segment_reader
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    frame_done,
    output logic                    pattern_err
`ifdef SEG_READER_ERR_CNT_EN
    ,
    output logic [7:0]              err_count
`endif
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STABLE_CYCLES - 2);

    seg_t                    seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d;
    seg_t                    seg_prev_q, seg_prev_d;
    logic [NUM_DIGITS-1:0]   an_s1_q, an_s1_d, an_s2_q, an_s2_d;
    logic [NUM_DIGITS-1:0]   an_prev_q, an_prev_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d;
    logic                    frame_done_q, frame_done_d;
    logic                    pattern_err_q, pattern_err_d;
`ifdef SEG_READER_ERR_CNT_EN
    logic [7:0]              err_cnt_q, err_cnt_d;
`endif

    logic [3:0]            dec_value;
    logic                  dec_blank;
    logic                  dec_err;
    logic [NUM_DIGITS-1:0] sel;
    logic [NUM_DIGITS-1:0] mask_next;
    int unsigned           low_cnt;
    logic                  an_ok;
    logic                  same;
    logic                  accept;

    seg_pattern_decode u_decode (
        .seg      (seg_s2_q),
        .value    (dec_value),
        .is_blank (dec_blank),
        .is_err   (dec_err)
    );

    always_comb begin
        seg_s1_d      = seg_in;
        seg_s2_d      = seg_s1_q;
        an_s1_d       = an_in;
        an_s2_d       = an_s1_q;
        seg_prev_d    = seg_s2_q;
        an_prev_d     = an_s2_q;
        cnt_d         = cnt_q;
        digits_d      = digits_q;
        valid_d       = valid_q;
        mask_d        = mask_q;
        frame_done_d  = 1'b0;
        pattern_err_d = 1'b0;
`ifdef SEG_READER_ERR_CNT_EN
        err_cnt_d     = err_cnt_q;
`endif

        // Active-low enables: the selected position is the single low bit.
        sel     = ~an_s2_q;
        low_cnt = 0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (sel[i]) low_cnt++;
        end
        an_ok = (low_cnt == 1);
        same  = (seg_s2_q == seg_prev_q) && (an_s2_q == an_prev_q);

        if (!an_ok || !same) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Fires only on the step into STABLE_CYCLES-1; saturation past it
        // keeps a long dwell from accepting again.
        accept    = an_ok && same && (cnt_q == CNT_PRE);
        mask_next = mask_q | sel;

        if (accept) begin
            if (dec_err) begin
                pattern_err_d = 1'b1;
`ifdef SEG_READER_ERR_CNT_EN
                if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
`endif
            end else begin
                for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                    if (sel[i]) begin
                        digits_d[4*i +: 4] = dec_blank ? DIGIT_BLANK : dec_value;
                        valid_d[i]         = !dec_blank;
                    end
                end
                if (&mask_next) begin
                    frame_done_d = 1'b1;
                    mask_d       = '0;
                end else begin
                    mask_d = mask_next;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_s1_q      <= '0;
            seg_s2_q      <= '0;
            an_s1_q       <= '0;
            an_s2_q       <= '0;
            seg_prev_q    <= '0;
            an_prev_q     <= '0;
            cnt_q         <= '0;
            digits_q      <= '1;
            valid_q       <= '0;
            mask_q        <= '0;
            frame_done_q  <= 1'b0;
            pattern_err_q <= 1'b0;
`ifdef SEG_READER_ERR_CNT_EN
            err_cnt_q     <= '0;
`endif
        end else begin
            seg_s1_q      <= seg_s1_d;
            seg_s2_q      <= seg_s2_d;
            an_s1_q       <= an_s1_d;
            an_s2_q       <= an_s2_d;
            seg_prev_q    <= seg_prev_d;
            an_prev_q     <= an_prev_d;
            cnt_q         <= cnt_d;
            digits_q      <= digits_d;
            valid_q       <= valid_d;
            mask_q        <= mask_d;
            frame_done_q  <= frame_done_d;
            pattern_err_q <= pattern_err_d;
`ifdef SEG_READER_ERR_CNT_EN
            err_cnt_q     <= err_cnt_d;
`endif
        end
    end

    assign digits      = digits_q;
    assign digit_valid = valid_q;
    assign frame_done  = frame_done_q;
    assign pattern_err = pattern_err_q;
`ifdef SEG_READER_ERR_CNT_EN
    assign err_count   = err_cnt_q;
`endif

endmodule

// File: tb/tb_seven_segment_reader.sv
// Scoreboard bench for seven_segment_reader. Each input dwell is handed to a
// reference model working in terms of whole dwells: a dwell of at least
// STABLE_CYCLES cycles with exactly one enable low is accepted once, and its
// effect appears STABLE_CYCLES+2 edges after the dwell starts. Observable
// outcomes are queued and a negedge monitor pops them as the DUT shows them.
module tb_seven_segment_reader;

    localparam int ND = 4;
    localparam int S  = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [6:0]      seg_in;
    logic [ND-1:0]   an_in;
    logic [4*ND-1:0] digits;
    logic [ND-1:0]   digit_valid;
    logic            frame_done;
    logic            pattern_err;
`ifdef SEG_READER_ERR_CNT_EN
    logic [7:0]      err_count;
`endif

    seven_segment_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(S)) dut (
        .clk         (clk),
        .reset       (reset),
        .seg_in      (seg_in),
        .an_in       (an_in),
        .digits      (digits),
        .digit_valid (digit_valid),
        .frame_done  (frame_done),
        .pattern_err (pattern_err)
`ifdef SEG_READER_ERR_CNT_EN
        ,
        .err_count   (err_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int              t;
        logic [4*ND-1:0] d;
        logic [ND-1:0]   v;
        logic            fd;
        logic            pe;
        logic [7:0]      ec;
    } exp_t;

    exp_t q[$];

    // Reference model state
    logic [6:0]      pats[10];
    logic [4*ND-1:0] m_digits;
    logic [ND-1:0]   m_valid;
    logic [ND-1:0]   m_mask;
    logic [7:0]      m_ec;
    logic [ND-1:0]   last_an;
    logic [6:0]      last_seg;

    task automatic model_reset();
        m_digits = '1;
        m_valid  = '0;
        m_mask   = '0;
        m_ec     = '0;
    endtask

    task automatic model_accept(input logic [ND-1:0] an, input logic [6:0] seg, input int t);
        int   pos = 0;
        int   val = -1;
        logic changed;
        exp_t e;
        for (int i = 0; i < ND; i++) if (!an[i]) pos = i;
        for (int k = 0; k < 10; k++) if (pats[k] == seg) val = k;
        e.fd = 1'b0;
        e.pe = 1'b0;
        changed = 1'b0;
        if (val < 0 && seg != 7'h7F) begin
            e.pe = 1'b1;
            if (m_ec != 8'd255) m_ec = m_ec + 8'd1;
        end else begin
            logic [3:0] nv;
            logic       nvalid;
            nv     = (val < 0) ? 4'hF : 4'(val);
            nvalid = (val >= 0);
            changed = (m_digits[4*pos +: 4] != nv) || (m_valid[pos] != nvalid);
            m_digits[4*pos +: 4] = nv;
            m_valid[pos] = nvalid;
            m_mask[pos] = 1'b1;
            if (m_mask == '1) begin
                e.fd = 1'b1;
                m_mask = '0;
            end
        end
        e.t  = t;
        e.d  = m_digits;
        e.v  = m_valid;
        e.ec = m_ec;
        if (e.pe || e.fd || changed) q.push_back(e);
    endtask

    // Called just after a rising edge; holds the inputs for len cycles.
    task automatic apply(input logic [ND-1:0] an, input logic [6:0] seg, input int len);
        an_in  = an;
        seg_in = seg;
        last_an  = an;
        last_seg = seg;
        if (len >= S && $countones(~an) == 1) model_accept(an, seg, cyc + S + 2);
        repeat (len) @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    // Monitor
    logic [4*ND-1:0] mon_d;
    logic [ND-1:0]   mon_v;
    always @(negedge clk) begin
        if (reset) begin
            mon_d = digits;
            mon_v = digit_valid;
        end else if (frame_done || pattern_err || digits != mon_d || digit_valid != mon_v) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event cyc=%0d digits=%h valid=%b fd=%b pe=%b required=no event",
                         cyc, digits, digit_valid, frame_done, pattern_err);
            end else begin
                exp_t e;
                logic bad;
                e = q.pop_front();
                bad = (e.t != cyc) || (e.d !== digits) || (e.v !== digit_valid) ||
                      (e.fd !== frame_done) || (e.pe !== pattern_err);
`ifdef SEG_READER_ERR_CNT_EN
                if (e.ec !== err_count) bad = 1'b1;
`endif
                if (bad) begin
                    failures++;
                    $display("FAIL accept_event got cyc=%0d digits=%h valid=%b fd=%b pe=%b required cyc=%0d digits=%h valid=%b fd=%b pe=%b ec=%0d",
                             cyc, digits, digit_valid, frame_done, pattern_err,
                             e.t, e.d, e.v, e.fd, e.pe, e.ec);
                end
            end
            mon_d = digits;
            mon_v = digit_valid;
        end
    end

    initial begin
        logic [ND-1:0] an;
        logic [6:0]    seg;
        int            len;
        int            r;

        pats = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        model_reset();
        reset  = 1'b1;
        an_in  = '1;
        seg_in = 7'h7F;
        last_an  = '1;
        last_seg = 7'h7F;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Idle after reset: nothing decoded, no pulses
        repeat (10) @(posedge clk);
        #1;
        check_val("reset_digits", 32'(digits), 32'hFFFF);
        check_val("reset_valid", 32'(digit_valid), 32'h0);
        check_val("reset_pulses", {30'd0, frame_done, pattern_err}, 32'h0);

        // Single digit held long: one accept only
        apply(4'b1110, 7'b0100100, 20);

        // Full scan 1,2,3,4
        apply(4'b1110, 7'b1111001, 8);
        apply(4'b1101, 7'b0100100, 8);
        apply(4'b1011, 7'b0110000, 8);
        apply(4'b0111, 7'b0011001, 8);

        // Undecodable pattern on position 1
        apply(4'b1101, 7'b0101010, 10);

        // Too-short dwells and a multi-low enable
        for (int i = 0; i < 8; i++) apply(4'b1011, (i % 2 == 0) ? 7'b1111001 : 7'b1111000, 2);
        apply(4'b1100, 7'b0000000, 12);
        apply(4'b1111, 7'h7F, S + 4);
        check_val("scan_digits", 32'(digits), 32'h4321);

        // Reset in the middle of a dwell
        an_in  = 4'b1101;
        seg_in = 7'b1111000;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_val("async_reset_digits", 32'(digits), 32'hFFFF);
        check_val("async_reset_valid", 32'(digit_valid), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        apply(4'b1101, 7'b1111000, 8);

        // Randomized dwells
        for (int n = 0; n < 80; n++) begin
            do begin
                if ($urandom_range(0, 99) < 85) begin
                    an = '1;
                    an[$urandom_range(0, ND - 1)] = 1'b0;
                end else begin
                    do an = ND'($urandom); while ($countones(~an) == 1);
                end
                r = $urandom_range(0, 99);
                if (r < 50)      seg = pats[$urandom_range(0, 9)];
                else if (r < 65) seg = 7'h7F;
                else             seg = 7'($urandom);
            end while (an == last_an && seg == last_seg);
            len = ($urandom_range(0, 99) < 70) ? $urandom_range(S, S + 6) : $urandom_range(1, S - 1);
            apply(an, seg, len);
        end

`ifdef SEG_READER_ERR_CNT_EN
        apply(4'b1111, 7'h7F, 3);
        for (int i = 0; i < 300; i++) apply(4'b1101, (i % 2 == 0) ? 7'b0101010 : 7'b0101011, S);
        repeat (S + 4) @(posedge clk);
        #1;
        check_val("err_count_sat", 32'(err_count), 32'd255);
`endif

        repeat (S + 4) @(posedge clk);
        #1;
        check_val("pending_events", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seven_segment_reader.md
SEVEN_SEGMENT_READER -- requirements
Module: seven_segment_reader

Interface
REQ-001 The module SHALL have parameter NUM_DIGITS, default 4, giving the number of multiplexed display positions.
REQ-002 The module SHALL have parameter STABLE_CYCLES, default 4 (minimum 2), giving the consecutive identical synchronized samples required to accept a pattern.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL be clocked on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port seg_in, input, 7 bits: active-low segment lines, bit6..bit0 = g..a.
REQ-006 Port an_in, input, NUM_DIGITS bits: active-low digit enables, one-hot-low when valid.
REQ-007 Port digits, output, 4*NUM_DIGITS bits: decoded value per position; position i occupies bits [4i+3:4i].
REQ-008 Port digit_valid, output, NUM_DIGITS bits: high when the position currently holds a decoded 0-9.
REQ-009 Port frame_done, output, 1 bit: one-cycle pulse when every position has been accepted since the last pulse.
REQ-010 Port pattern_err, output, 1 bit: one-cycle pulse on acceptance of an undecodable pattern.

Function
REQ-011 seg_in and an_in SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 A stability counter SHALL clear to 0 when the synchronized {an,seg} sample differs from the previous one, and increment (saturating at STABLE_CYCLES) when it matches.
REQ-013 Acceptance SHALL occur exactly once per dwell, on the cycle the counter reaches STABLE_CYCLES-1.
REQ-014 With default STABLE_CYCLES=4, outputs SHALL update on the 6th rising edge after inputs become stable.
REQ-015 Decoded patterns SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-016 On a valid pattern, the addressed position SHALL load the value and set digit_valid.
REQ-017 On blank (1111111), the position SHALL load 4'hF and clear digit_valid.
REQ-018 Any other pattern SHALL leave the position unchanged and pulse pattern_err.
REQ-019 When an_in has zero or multiple lows, the sample SHALL be ignored, with no accept, no error and the counter held at 0.
REQ-020 Valid and blank accepts SHALL set the position's bit in an internal seen-mask; error accepts SHALL NOT.
REQ-021 When the mask becomes all ones, frame_done SHALL pulse and the mask SHALL clear in the same cycle; re-accepting a seen position SHALL NOT change the mask.

Reset
REQ-022 Reset SHALL force digits to all 4'hF and clear digit_valid, frame_done, pattern_err, the seen-mask, the counter and the synchronizers.
REQ-023 Reset SHALL take precedence over every simultaneous event.
REQ-024 Reset asserted mid-dwell SHALL discard the partial dwell; after release, a fresh STABLE_CYCLES dwell is required.

Configuration
REQ-025 Macro SEG_READER_ERR_CNT_EN, when defined, SHALL add output err_count (8 bits, reset 0) that increments on every pattern_err pulse and saturates at 255.
REQ-026 Without SEG_READER_ERR_CNT_EN, err_count and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-027 Package seven_seg_pkg SHALL hold the ten segment-pattern constants, SEG_BLANK, DIGIT_BLANK (4'hF), and a seg_t 7-bit typedef.
REQ-028 Sub-module seg_pattern_decode SHALL be purely combinational: input seg_t, outputs 4-bit value, is_blank and is_err.

Verification
REQ-029 After reset, with no further stimulus, digits SHALL read all F, digit_valid SHALL read 0, and neither pulse output SHALL fire.
REQ-030 Holding an_in=1110 and seg_in=0100100 for 6 cycles SHALL make digits[3:0]=2 and digit_valid[0]=1 at edge 6, with no second accept while held.
REQ-031 Scanning positions 0-3 with patterns 1,2,3,4 (8 cycles each) SHALL give digits=16'h4321 and a single frame_done pulse after position 3.
REQ-032 Holding seg_in=0101010 on position 1 SHALL produce one pattern_err pulse, leave the position unchanged and produce no frame_done.
REQ-033 Toggling seg_in every 2 cycles, or driving an_in=1100, SHALL produce no accepts.
REQ-034 With SEG_READER_ERR_CNT_EN defined, 300 error accepts SHALL leave err_count=255.
